mem_wb_stage: RTL

- MEM/WB pipeline register plus write-back formatting for the pipelined CPU.
- Sits directly upstream of the register file. It latches the MEM-stage result and performs load extraction and sign/zero extension or link-address generation.
- Drives the register file's write port (regW, Wdat, RegWrite) and exposes the same values for forwarding.
- Keeps a retired-instruction counter.

---
 rtl/mem_wb_stage_if.sv | 32 +++
 rtl/mem_wb_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// Bundle between the MEM stage, the MEM/WB stage and the register-file write port.
// The master drives MEM results and pipeline control. The slave is the stage and returns the WB values.
interface mem_wb_stage_if;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_RegWrite;
    logic [4:0]  mem_regW;
    logic [1:0]  mem_WBSel;
    logic [2:0]  mem_LoadType;
    logic [1:0]  mem_ByteOff;
    logic [31:0] mem_alu;
    logic [31:0] mem_rdata;
    logic [31:0] mem_pc;
    logic [4:0]  regW;
    logic [31:0] Wdat;
    logic        RegWrite;
    logic        wb_valid;
    logic [31:0] instret;

    modport master (
        output stall, flush, mem_valid, mem_RegWrite, mem_regW, mem_WBSel,
               mem_LoadType, mem_ByteOff, mem_alu, mem_rdata, mem_pc,
        input  regW, Wdat, RegWrite, wb_valid, instret
    );

    modport slave (
        input  stall, flush, mem_valid, mem_RegWrite, mem_regW, mem_WBSel,
               mem_LoadType, mem_ByteOff, mem_alu, mem_rdata, mem_pc,
        output regW, Wdat, RegWrite, wb_valid, instret
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction/extension, link-address generation
// and a retired-instruction counter. It feeds the register-file write port.
module mem_wb_stage #(
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  wb
);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    logic        valid_r;
    logic        regwrite_r;
    logic [4:0]  regw_r;
    logic [1:0]  wbsel_r;
    logic [2:0]  loadtype_r;
    logic [1:0]  byteoff_r;
    logic [31:0] alu_r;
    logic [31:0] rdata_r;
    logic [31:0] pc_r;
    logic [31:0] instret_r;

    logic [31:0] wdat_s;
    logic        regwrite_s;

    // Little-endian lane select. A halfword ignores ByteOff[0], so a misaligned halfword reads the aligned lane.
    function automatic logic [31:0] format_load(
        input logic [2:0]  load_type,
        input logic [1:0]  byte_off,
        input logic [31:0] rdata
    );
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [31:0] res_v;
        half_v = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (byte_off)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        case (load_type)
            LT_LW:   res_v = rdata;
            LT_LH:   res_v = {{16{half_v[15]}}, half_v};
            LT_LHU:  res_v = {16'h0000, half_v};
            LT_LB:   res_v = {{24{byte_v[7]}}, byte_v};
            LT_LBU:  res_v = {24'h000000, byte_v};
            default: res_v = rdata;
        endcase
        return res_v;
    endfunction

    // WB entry register. Flush has priority over stall, and stall has priority over capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r    <= 1'b0;
            regwrite_r <= 1'b0;
            regw_r     <= 5'd0;
            wbsel_r    <= 2'b00;
            loadtype_r <= 3'b000;
            byteoff_r  <= 2'b00;
            alu_r      <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
            pc_r       <= 32'h0000_0000;
        end else if (wb.flush) begin
            valid_r    <= 1'b0;
            regwrite_r <= 1'b0;
        end else if (!wb.stall) begin
            valid_r    <= wb.mem_valid;
            regwrite_r <= wb.mem_RegWrite;
            regw_r     <= wb.mem_regW;
            wbsel_r    <= wb.mem_WBSel;
            loadtype_r <= wb.mem_LoadType;
            byteoff_r  <= wb.mem_ByteOff;
            alu_r      <= wb.mem_alu;
            rdata_r    <= wb.mem_rdata;
            pc_r       <= wb.mem_pc;
        end else begin
            valid_r    <= valid_r;
            regwrite_r <= regwrite_r;
        end
    end

    // Retired-instruction counter. It counts only real instructions that are captured, and it wraps modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_r <= 32'h0000_0000;
        end else if (!wb.flush && !wb.stall && wb.mem_valid) begin
            instret_r <= instret_r + 32'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    // Write-back data selection from the stored fields.
    always_comb begin
        wdat_s = alu_r;
        case (wbsel_r)
            WB_ALU:  wdat_s = alu_r;
            WB_LOAD: wdat_s = format_load(loadtype_r, byteoff_r, rdata_r);
            WB_LINK: wdat_s = pc_r + LINK_OFFSET;
            default: wdat_s = alu_r;
        endcase
    end

    // r0 is hardwired, so a write to it is never issued.
    always_comb begin
        regwrite_s = valid_r & regwrite_r & (regw_r != 5'd0);
    end

    assign wb.regW     = regw_r;
    assign wb.Wdat     = wdat_s;
    assign wb.RegWrite = regwrite_s;
    assign wb.wb_valid = valid_r;
    assign wb.instret  = instret_r;

endmodule
